// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache in front of the AXI bridge's inst port.
// Cacheable hits return in one cycle. Misses and uncached fetches issue a single-word read.
`timescale 1ns/1ps
module inst_cache #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    // CPU fetch side
    input  logic        cpu_req,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_addr,
    output logic        cpu_addr_ok,
    output logic        cpu_data_ok,
    output logic [31:0] cpu_rdata,
    // bridge side
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [3:0]  inst_wstrb,
    output logic [31:0] inst_wdata,
    input  logic [31:0] inst_rdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok
);

    localparam int unsigned LINES    = 1 << INDEX_BITS;
    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StMissReq,
        StMissWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [31:0]           addr_q;
    logic [1:0]            size_q;
    logic                  uncached_q;
    logic                  kill_q, kill_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;
    logic                  fill_en;

    assign idx = addr_q[INDEX_BITS+1:2];
    assign tag = addr_q[31:INDEX_BITS+2];

    // A flush arriving in the lookup cycle must not let a stale line hit.
    assign hit = !uncached_q && valid_q[idx] && (tag_mem[idx] == tag) && !flush;

    assign inst_wr    = 1'b0;
    assign inst_wstrb = 4'b0000;
    assign inst_wdata = 32'h0;

    // addr_q only changes in idle, so the bridge request stays stable while inst_req is high.
    assign inst_addr = uncached_q ? addr_q : {addr_q[31:2], 2'b00};
    assign inst_size = uncached_q ? size_q : 2'd2;

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        fill_en     = 1'b0;
        cpu_addr_ok = 1'b0;
        cpu_data_ok = 1'b0;
        cpu_rdata   = rdata_q;
        inst_req    = 1'b0;

        unique case (state_q)
            StIdle: begin
                cpu_addr_ok = 1'b1;
                if (cpu_req) begin
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit) begin
                    cpu_data_ok = 1'b1;
                    cpu_rdata   = data_mem[idx];
                    state_d     = StIdle;
                end else begin
                    state_d = StMissReq;
                end
            end
            StMissReq: begin
                inst_req = 1'b1;
                if (inst_addr_ok) begin
                    state_d = StMissWait;
                end
            end
            StMissWait: begin
                if (inst_data_ok) begin
                    rdata_d = inst_rdata;
                    fill_en = !uncached_q && !kill_q && !flush;
                    state_d = StResp;
                end
            end
            StResp: begin
                cpu_data_ok = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A flush while a refill is in flight must stop that refill from landing.
    always_comb begin
        kill_d = kill_q;
        if (state_d == StIdle) begin
            kill_d = 1'b0;
        end else if (flush && (state_q == StMissReq || state_q == StMissWait)) begin
            kill_d = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (fill_en) begin
            valid_d[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            kill_q     <= 1'b0;
            rdata_q    <= 32'h0;
            valid_q    <= '0;
            addr_q     <= 32'h0;
            size_q     <= 2'd0;
            uncached_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            if (state_q == StIdle && cpu_req) begin
                addr_q     <= cpu_addr;
                size_q     <= cpu_size;
                uncached_q <= (cpu_addr[31:29] == 3'b101);
            end
        end
    end

    // Tag and data arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= inst_rdata;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Randomized self-checking bench for inst_cache against a line-table reference model.
`timescale 1ns/1ps
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        cpu_req;
    logic [1:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic        cpu_addr_ok;
    logic        cpu_data_ok;
    logic [31:0] cpu_rdata;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_wdata;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;

    int total = 0;
    int bad   = 0;

    // Reference model: one entry per line, indexed by plain address arithmetic.
    bit          ref_valid [64];
    int unsigned ref_tag   [64];

    always #5 clk = ~clk;

    inst_cache #(.INDEX_BITS(6)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush        (flush),
        .cpu_req      (cpu_req),
        .cpu_size     (cpu_size),
        .cpu_addr     (cpu_addr),
        .cpu_addr_ok  (cpu_addr_ok),
        .cpu_data_ok  (cpu_data_ok),
        .cpu_rdata    (cpu_rdata),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_addr    (inst_addr),
        .inst_wstrb   (inst_wstrb),
        .inst_wdata   (inst_wdata),
        .inst_rdata   (inst_rdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h2408_0001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic bit is_cached(input logic [31:0] a);
        return (a >> 29) != 32'd5;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        model_clear();
        @(negedge clk);
        check("flush_idle_no_data", cpu_data_ok, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0;
    endtask

    // Called just after a rising edge with the DUT idle. flush_at: -1 none, -2 during lookup,
    // k>=0 during the k-th cycle of the data wait.
    task automatic fetch(input logic [31:0] a, input logic [1:0] sz, input int aok_dly,
                         input int dok_dly, input int flush_at, input bit spurious);
        int unsigned idx    = (a >> 2) % 64;
        int unsigned tg     = a >> 8;
        bit          cached = is_cached(a);
        bit          exp_hit;
        bit          killed = 1'b0;
        logic [31:0] exp_addr = cached ? (a & 32'hFFFF_FFFC) : a;
        logic [1:0]  exp_size = cached ? 2'd2 : sz;

        exp_hit  = cached && ref_valid[idx] && (ref_tag[idx] == tg);
        cpu_req  = 1'b1;
        cpu_addr = a;
        cpu_size = sz;
        @(negedge clk);
        check("idle_addr_ok", cpu_addr_ok, 1'b1);
        @(posedge clk);
        #1 cpu_req = 1'b0;
        cpu_addr = $urandom;
        if (flush_at == -2) begin
            flush = 1'b1;
            model_clear();
            exp_hit = 1'b0;
        end
        @(negedge clk);
        check("lookup_addr_ok", cpu_addr_ok, 1'b0);
        check("lookup_no_req", inst_req, 1'b0);
        if (exp_hit) begin
            check("hit_data_ok", cpu_data_ok, 1'b1);
            check("hit_rdata", cpu_rdata, mem_word(a));
            @(posedge clk);
            #1;
            return;
        end
        check("miss_no_data_ok", cpu_data_ok, 1'b0);
        @(posedge clk);
        #1 flush = 1'b0;
        for (int c = 0; c <= aok_dly; c++) begin
            inst_addr_ok = (c == aok_dly);
            inst_data_ok = (spurious && c != aok_dly) ? 1'b1 : 1'b0;
            inst_rdata   = $urandom;
            @(negedge clk);
            check("req_high", inst_req, 1'b1);
            check("req_addr", inst_addr, exp_addr);
            check("req_size", {30'b0, inst_size}, {30'b0, exp_size});
            check("req_addr_ok_low", cpu_addr_ok, 1'b0);
            check("req_no_data_ok", cpu_data_ok, 1'b0);
            @(posedge clk);
            #1;
        end
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        for (int c = 0; c <= dok_dly; c++) begin
            if (flush_at == c) begin
                flush = 1'b1;
                model_clear();
                killed = 1'b1;
            end
            inst_data_ok = (c == dok_dly);
            inst_rdata   = (c == dok_dly) ? mem_word(a) : $urandom;
            @(negedge clk);
            check("wait_req_low", inst_req, 1'b0);
            check("wait_no_data_ok", cpu_data_ok, 1'b0);
            @(posedge clk);
            #1 flush = 1'b0;
        end
        inst_data_ok = 1'b0;
        inst_rdata   = $urandom;
        @(negedge clk);
        check("resp_data_ok", cpu_data_ok, 1'b1);
        check("resp_rdata", cpu_rdata, mem_word(a));
        check("resp_req_low", inst_req, 1'b0);
        if (cached && !killed) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_in_wait(input logic [31:0] a);
        cpu_req  = 1'b1;
        cpu_addr = a;
        cpu_size = 2'd2;
        @(posedge clk);
        #1 cpu_req = 1'b0;
        @(posedge clk);
        #1 inst_addr_ok = 1'b1;
        @(negedge clk);
        check("rst_pre_req", inst_req, 1'b1);
        @(posedge clk);
        #1 inst_addr_ok = 1'b0;
        resetn = 1'b0;
        model_clear();
        #1;
        check("rst_async_req", inst_req, 1'b0);
        check("rst_async_data_ok", cpu_data_ok, 1'b0);
        check("rst_async_addr_ok", cpu_addr_ok, 1'b1);
        check("rst_async_rdata", cpu_rdata, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        inst_data_ok = 1'b1;
        inst_rdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        check("late_data_ok_ignored", cpu_data_ok, 1'b0);
        @(posedge clk);
        #1 inst_data_ok = 1'b0;
        @(negedge clk);
        check("late_no_resp", cpu_data_ok, 1'b0);
        check("late_idle", cpu_addr_ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn       = 1'b0;
        flush        = 1'b0;
        cpu_req      = 1'b0;
        cpu_size     = 2'd2;
        cpu_addr     = 32'h0;
        inst_rdata   = 32'h0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_addr_ok", cpu_addr_ok, 1'b1);
        check("rst_data_ok", cpu_data_ok, 1'b0);
        check("rst_inst_req", inst_req, 1'b0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("tie_wr", inst_wr, 1'b0);
        check("tie_wstrb", {28'b0, inst_wstrb}, 32'h0);
        check("tie_wdata", inst_wdata, 32'h0);
        @(posedge clk);
        #1;

        // cold miss, hit, conflict
        fetch(32'h0000_0100, 2'd2, 0, 0, -1, 1'b0);
        fetch(32'h0000_0100, 2'd2, 0, 0, -1, 1'b0);
        fetch(32'h0000_0200, 2'd2, 0, 1, -1, 1'b0);
        fetch(32'h0000_0100, 2'd2, 1, 0, -1, 1'b0);
        // uncached never hits
        fetch(32'hBFC0_0000, 2'd2, 0, 0, -1, 1'b0);
        fetch(32'hBFC0_0000, 2'd2, 0, 0, -1, 1'b0);
        fetch(32'hBFC0_0002, 2'd1, 1, 1, -1, 1'b0);
        // flush in idle, during wait, on the fill cycle, during lookup
        do_flush();
        fetch(32'h0000_0100, 2'd2, 0, 0, -1, 1'b0);
        fetch(32'h0000_0104, 2'd2, 0, 2, 1, 1'b0);
        fetch(32'h0000_0104, 2'd2, 0, 0, -1, 1'b0);
        fetch(32'h0000_010C, 2'd2, 0, 1, 1, 1'b0);
        fetch(32'h0000_010C, 2'd2, 0, 0, -1, 1'b0);
        fetch(32'h0000_010C, 2'd2, 0, 0, -2, 1'b0);
        fetch(32'h0000_010C, 2'd2, 0, 0, -1, 1'b0);
        // stalled bridge with spurious data_ok
        fetch(32'h0000_0108, 2'd2, 5, 1, -1, 1'b1);
        fetch(32'h0000_0108, 2'd2, 0, 0, -1, 1'b0);
        // reset during the data wait
        fetch(32'h0000_0308, 2'd2, 0, 0, -1, 1'b0);
        reset_in_wait(32'h0000_030C);
        fetch(32'h0000_030C, 2'd2, 0, 0, -1, 1'b0);
        fetch(32'h0000_0308, 2'd2, 0, 0, -1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [1:0]  sz = 2'd2;
            int          fa = -1;
            int          dd = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
                a  = 32'hBFC0_0000 | ($urandom & 32'hFF);
                sz = 2'($urandom_range(0, 2));
            end else begin
                a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            end
            case ($urandom_range(0, 9))
                0:       fa = -2;
                1:       fa = $urandom_range(0, dd);
                default: fa = -1;
            endcase
            if ($urandom_range(0, 19) == 0) do_flush();
            fetch(a, sz, $urandom_range(0, 3), dd, fa, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
